signed_compare_serial: RTL and testbench

- Bit-serial signed two's-complement magnitude comparator; processes LSB-first, opposite to the MSB-sign-first combinational less-than path.
- Computes A − B one bit per cycle using a single full-adder cell and a carry flop. Derives gt, eq and lt from the final sign, the overflow and a running zero flag.
- Sits beside the combinational comparator in the Adder area, for area-constrained datapaths that accept WIDTH+1 cycles of latency.
- Uses a start/busy/done handshake.

---
 rtl/compare_pkg.sv | 13 +
 rtl/serial_sub_cell.sv | 19 +
 rtl/signed_compare_serial.sv | 111 +++++++++++
 tb/tb_signed_compare_serial.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared types for the bit-serial signed comparator.
// Holds the FSM state encoding and the default operand width.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 5;

endpackage

// File: rtl/serial_sub_cell.sv
// One full-adder slice used to form A + ~B + 1 one bit per cycle.
// Purely combinational; the carry flop lives in the parent.
module serial_sub_cell
  import compare_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic d,
  output logic cout
);

  // sum and majority carry of the three inputs
  always_comb begin
    d    = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule

// File: rtl/signed_compare_serial.sv
// LSB-first serial signed comparator: subtracts B from A over WIDTH
// cycles and derives gt/eq/lt from the sign, overflow and zero flag.
module signed_compare_serial
  import compare_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic             zero;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             cout;
  logic             last;
  logic             zero_nx;
  logic             ovf;
  logic             neg;

  serial_sub_cell u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (carry),
    .d    (d),
    .cout (cout)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign zero_nx = zero & ~d;
  // at the MSB, carry is the carry into the sign bit
  assign ovf     = carry ^ cout;
  assign neg     = d ^ ovf;

  // next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // operand shifters, carry, zero flag and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      cnt   <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sa    <= a;
        sb    <= ~b;
        carry <= 1'b1;
        zero  <= 1'b1;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        zero  <= zero_nx;
        carry <= cout;
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        cnt   <= cnt + CW'(1);
        if (last) begin
          lt <= neg;
          eq <= zero_nx;
          gt <= ~neg & ~zero_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_compare_serial.sv
// Directed bench for the serial signed comparator, WIDTH = 5.
// Each scenario task drives stimulus and checks results inline.
module tb_signed_compare_serial;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int checks   = 0;
  int failures = 0;

  signed_compare_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  // one start pulse, wait for done (bounded), then let it go idle
  task automatic do_cmp(
    input  logic [W-1:0] av,
    input  logic [W-1:0] bv,
    output logic [2:0]   res,
    output int           lat
  );
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = {gt, eq, lt};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if ({gt, eq, lt} !== 3'b000) begin
      failures++;
      $display("FAIL reset_res got=%b exp=000", {gt, eq, lt});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_equal;
    int nb;
    int dpos;
    int nd;
    logic [2:0] res;
    nb = 0;
    dpos = -1;
    nd = 0;
    res = 3'b000;
    @(negedge clk);
    a = 5'd7;
    b = 5'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin
        nd++;
        dpos = nb;
        res = {gt, eq, lt};
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (nb != 6) begin
      failures++;
      $display("FAIL eq_busy_cycles got=%0d exp=6", nb);
    end
    checks++;
    if (dpos != 6) begin
      failures++;
      $display("FAIL eq_done_pos got=%0d exp=6", dpos);
    end
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL eq_done_count got=%0d exp=1", nd);
    end
    checks++;
    if (res !== 3'b010) begin
      failures++;
      $display("FAIL eq_result got=%b exp=010", res);
    end
  endtask

  task automatic test_overflow;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [2:0]   ve [4];
    logic [2:0]   res;
    int lat;
    va[0] = 5'b10000; vb[0] = 5'b01111; ve[0] = 3'b001;
    va[1] = 5'b01111; vb[1] = 5'b10000; ve[1] = 3'b100;
    va[2] = 5'b11111; vb[2] = 5'b11110; ve[2] = 3'b100;
    va[3] = 5'b11110; vb[3] = 5'b11111; ve[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      do_cmp(va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i] || lat != W) begin
        failures++;
        $display("FAIL ovf_vec%0d got=%b lat=%0d exp=%b lat=%0d",
                 i, res, lat, ve[i], W);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int nd;
    logic [2:0] res;
    nd = 0;
    res = 3'b000;
    @(negedge clk);
    a = 5'd3;
    b = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    a = 5'd9;
    b = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) begin
        nd++;
        res = {gt, eq, lt};
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d exp=1", nd);
    end
    checks++;
    if (res !== 3'b001) begin
      failures++;
      $display("FAIL ignore_result got=%b exp=001", res);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    logic [2:0] res;
    int lat;
    nd = 0;
    @(negedge clk);
    a = 5'd5;
    b = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_hs got=%b%b exp=00", busy, done);
    end
    checks++;
    if ({gt, eq, lt} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_res got=%b exp=000", {gt, eq, lt});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      failures++;
      $display("FAIL mid_reset_nodone got=%0d exp=0", nd);
    end
    do_cmp(5'd0, 5'd0, res, lat);
    checks++;
    if (res !== 3'b010 || lat != W) begin
      failures++;
      $display("FAIL mid_reset_after got=%b lat=%0d exp=010 lat=%0d",
               res, lat, W);
    end
  endtask

  task automatic test_back_to_back;
    int t [3];
    int n;
    int ng;
    n = 0;
    ng = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    @(negedge clk);
    a = 5'd1;
    b = 5'd0;
    start = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        t[n] = c;
        n++;
        if ({gt, eq, lt} === 3'b100) ng++;
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=3", n);
    end
    checks++;
    if (t[1] - t[0] != 7 || t[2] - t[1] != 7) begin
      failures++;
      $display("FAIL b2b_period got=%0d,%0d exp=7,7",
               t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (ng != 3) begin
      failures++;
      $display("FAIL b2b_gt got=%0d exp=3", ng);
    end
  endtask

  task automatic test_sweep;
    logic [2:0] res;
    logic [2:0] exp;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    int lat;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        sa = W'(i);
        sb = W'(j);
        exp = {sa > sb, sa == sb, sa < sb};
        do_cmp(sa, sb, res, lat);
        checks++;
        if (res !== exp || lat != W) begin
          failures++;
          $display("FAIL sweep a=%0d b=%0d got=%b lat=%0d exp=%b",
                   sa, sb, res, lat, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_overflow;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
